// File: rtl/bcd_incr_scheduler_if.sv
// Requester, completion and incrementor-side signals of the BCD incrementor scheduler.
// slave = the scheduler; master = the requesters plus the incrementor data path.
interface bcd_incr_scheduler_if;
    logic        req_a;
    logic        req_b;
    logic        clr_req;
    logic [15:0] cnt_data;
    logic        cnt_incr;
    logic        cnt_reset;
    logic        ack_a;
    logic        ack_b;
    logic        clr_ack;
    logic [15:0] snap;
    logic        wrap;
    logic        busy;

    modport slave (
        input  req_a, req_b, clr_req, cnt_data,
        output cnt_incr, cnt_reset, ack_a, ack_b, clr_ack, snap, wrap, busy
    );

    modport master (
        output req_a, req_b, clr_req, cnt_data,
        input  cnt_incr, cnt_reset, ack_a, ack_b, clr_ack, snap, wrap, busy
    );
endinterface

// File: rtl/bcd_incr_scheduler.sv
// Shares one BCD incrementor between two round-robin increment channels and a priority clear.
// Ack 2+SETTLE_CYCLES edges after the request is sampled; requests are levels held until their ack.
module bcd_incr_scheduler #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_incr_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        STROBE_INC,
        STROBE_CLR,
        SETTLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] settle_cnt;
    logic [3:0] settle_cnt_nxt;
    logic       grant_b;
    logic       grant_b_nxt;
    logic       op_clr;
    logic       op_clr_nxt;
    logic       rr_ptr_b;
    logic       done_entry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            grant_b    <= 1'b0;
            op_clr     <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            grant_b    <= grant_b_nxt;
            op_clr     <= op_clr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        grant_b_nxt    = grant_b;
        op_clr_nxt     = op_clr;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_nxt  = STROBE_CLR;
                    op_clr_nxt = 1'b1;
                end else if (bus.req_a || bus.req_b) begin
                    state_nxt   = STROBE_INC;
                    op_clr_nxt  = 1'b0;
                    // B wins when it asks alone, or on a tie when the pointer favours it
                    grant_b_nxt = bus.req_b && (!bus.req_a || rr_ptr_b);
                end
            end
            STROBE_INC, STROBE_CLR: begin
                state_nxt      = SETTLE;
                settle_cnt_nxt = SETTLE_LOAD;
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_nxt = DONE;
                end else begin
                    settle_cnt_nxt = settle_cnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign done_entry = (state == SETTLE) && (settle_cnt == 4'd0);

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.cnt_incr  <= 1'b0;
            bus.cnt_reset <= 1'b1;
            bus.ack_a     <= 1'b0;
            bus.ack_b     <= 1'b0;
            bus.clr_ack   <= 1'b0;
            bus.snap      <= 16'h0000;
            bus.wrap      <= 1'b0;
            bus.busy      <= 1'b0;
            rr_ptr_b      <= 1'b0;
        end else begin
            bus.cnt_incr  <= (state_nxt == STROBE_INC);
            bus.cnt_reset <= (state_nxt == STROBE_CLR);
            bus.busy      <= (state_nxt != IDLE);
            bus.ack_a     <= done_entry && !op_clr && !grant_b;
            bus.ack_b     <= done_entry && !op_clr && grant_b;
            bus.clr_ack   <= done_entry && op_clr;
            bus.wrap      <= done_entry && !op_clr && (bus.cnt_data == 16'h0000);
            if (done_entry) begin
                bus.snap <= bus.cnt_data;
                if (!op_clr) begin
                    rr_ptr_b <= !grant_b;
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_incr_scheduler.sv
// Bench for bcd_incr_scheduler: behavioural incrementor, transaction-level reference model,
// directed scenarios followed by randomized request traffic with occasional resets.
module tb_bcd_incr_scheduler;
    localparam int S      = 1;
    localparam int OP_A   = 0;
    localparam int OP_B   = 1;
    localparam int OP_CLR = 2;

    logic clk;
    logic rst;

    bcd_incr_scheduler_if bus();

    bcd_incr_scheduler #(.SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          env_val  = 0;
    int          ref_count = 0;
    int          ref_k    = -1;
    int          ref_op   = OP_A;
    logic        ref_ptr_b = 1'b0;
    logic [15:0] ref_snap = 16'h0000;
    int          rearm_a  = 0;
    int          rearm_b  = 0;
    int          n_incr   = 0;
    int          n_wrap   = 0;
    int          ack_log[$];
    logic [15:0] snap_log[$];

    function automatic logic [15:0] to_bcd(input int v);
        return {4'd0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: reference decision, edge, incrementor update, full output comparison.
    task automatic step();
        logic pre_incr;
        logic pre_clr;
        logic pre_rst;
        logic e_wrap;
        pre_incr = bus.cnt_incr;
        pre_clr  = bus.cnt_reset;
        pre_rst  = rst;
        e_wrap   = 1'b0;
        if (pre_rst) begin
            ref_k     = -1;
            ref_ptr_b = 1'b0;
            ref_count = 0;
            ref_snap  = 16'h0000;
        end else if (ref_k < 0 || ref_k >= S + 2) begin
            ref_k = -1;
            if (bus.clr_req) begin
                ref_op = OP_CLR; ref_k = 0;
            end else if (bus.req_a && (!bus.req_b || !ref_ptr_b)) begin
                ref_op = OP_A; ref_k = 0;
            end else if (bus.req_b) begin
                ref_op = OP_B; ref_k = 0;
            end
        end else begin
            ref_k++;
        end
        if (ref_k == S + 1) begin
            ref_count = (ref_op == OP_CLR) ? 0 : (ref_count + 1) % 1000;
            ref_snap  = to_bcd(ref_count);
            e_wrap    = (ref_op != OP_CLR) && (ref_count == 0);
            if (ref_op == OP_A) ref_ptr_b = 1'b1;
            if (ref_op == OP_B) ref_ptr_b = 1'b0;
        end

        @(posedge clk);
        #1;
        if (pre_clr) env_val = 0;
        else if (pre_incr) env_val = (env_val + 1) % 1000;
        bus.cnt_data = to_bcd(env_val);

        check("busy",      bus.busy,      32'(ref_k >= 0 && ref_k <= S + 1));
        check("cnt_incr",  bus.cnt_incr,  32'(ref_k == 0 && ref_op != OP_CLR));
        check("cnt_reset", bus.cnt_reset, 32'(pre_rst || (ref_k == 0 && ref_op == OP_CLR)));
        check("ack_a",     bus.ack_a,     32'(ref_k == S + 1 && ref_op == OP_A));
        check("ack_b",     bus.ack_b,     32'(ref_k == S + 1 && ref_op == OP_B));
        check("clr_ack",   bus.clr_ack,   32'(ref_k == S + 1 && ref_op == OP_CLR));
        check("wrap",      bus.wrap,      32'(e_wrap));
        check("snap",      bus.snap,      32'(ref_snap));

        n_incr += 32'(bus.cnt_incr);
        n_wrap += 32'(bus.wrap);
        if (bus.ack_a) begin
            ack_log.push_back(OP_A); snap_log.push_back(bus.snap);
            if (rearm_a > 0) rearm_a--; else bus.req_a = 1'b0;
        end
        if (bus.ack_b) begin
            ack_log.push_back(OP_B); snap_log.push_back(bus.snap);
            if (rearm_b > 0) rearm_b--; else bus.req_b = 1'b0;
        end
        if (bus.clr_ack) begin
            ack_log.push_back(OP_CLR); snap_log.push_back(bus.snap);
            bus.clr_req = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_acks(input int n, output int steps);
        steps = 0;
        while (ack_log.size() < n && steps < 200) begin
            step();
            steps++;
        end
        check("ack_timeout", 32'(ack_log.size()), 32'(n));
    endtask

    task automatic preload(input int v);
        env_val      = v;
        ref_count    = v;
        bus.cnt_data = to_bcd(v);
    endtask

    initial begin
        int base;
        int steps;
        int v0;
        int ni;
        int nw;

        bus.req_a    = 1'b0;
        bus.req_b    = 1'b0;
        bus.clr_req  = 1'b0;
        bus.cnt_data = 16'h0000;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_cnt_reset", bus.cnt_reset, 1);
        check("rst_snap", bus.snap, 0);
        idle(3);
        rst = 1'b0;
        step();
        check("release_cnt_reset", bus.cnt_reset, 0);
        idle(2);

        // Contention: both channels held for four transactions
        base = ack_log.size();
        v0 = env_val;
        rearm_a = 1; rearm_b = 1;
        bus.req_a = 1'b1; bus.req_b = 1'b1;
        run_until_acks(base + 4, steps);
        for (int i = 0; i < 4; i++)
            check("cont_order", 32'(ack_log[base + i]), 32'((i % 2 == 0) ? OP_A : OP_B));
        check("cont_count_delta", 32'(env_val - v0), 4);
        idle(3);

        // Clear wins over two pending increments
        preload(123);
        base = ack_log.size();
        bus.clr_req = 1'b1; bus.req_a = 1'b1; bus.req_b = 1'b1;
        run_until_acks(base + 3, steps);
        check("clrpri_op0", 32'(ack_log[base]), OP_CLR);
        check("clrpri_snap0", snap_log[base], 16'h0000);
        check("clrpri_op1", 32'(ack_log[base + 1]), OP_A);
        check("clrpri_snap1", snap_log[base + 1], 16'h0001);
        check("clrpri_op2", 32'(ack_log[base + 2]), OP_B);
        check("clrpri_snap2", snap_log[base + 2], 16'h0002);
        idle(3);

        // Single request latency and value
        preload(41);
        base = ack_log.size();
        ni = n_incr;
        bus.req_a = 1'b1;
        run_until_acks(base + 1, steps);
        check("single_latency", 32'(steps), 3);
        check("single_snap", snap_log[base], 16'h0042);
        check("single_wrap", bus.wrap, 0);
        check("single_incr_pulses", 32'(n_incr - ni), 1);
        idle(3);

        // Wrap from 999
        preload(999);
        base = ack_log.size();
        nw = n_wrap;
        bus.req_a = 1'b1;
        run_until_acks(base + 1, steps);
        check("wrap_snap", snap_log[base], 16'h0000);
        idle(3);
        check("wrap_pulses", 32'(n_wrap - nw), 1);
        check("wrap_d3", 32'(bus.snap[15:12]), 0);

        // Reset while the operation is settling
        base = ack_log.size();
        bus.req_a = 1'b1;
        step();
        step();
        rst = 1'b1;
        bus.req_a = 1'b0;
        #1;
        check("midrst_cnt_reset", bus.cnt_reset, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_snap", bus.snap, 0);
        idle(2);
        check("midrst_no_ack", 32'(ack_log.size()), 32'(base));
        rst = 1'b0;
        idle(2);
        bus.req_b = 1'b1;
        run_until_acks(base + 1, steps);
        check("midrst_op", 32'(ack_log[base]), OP_B);
        check("midrst_snap_after", snap_log[base], 16'h0001);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            step();
            if (!bus.req_a) begin
                if ($urandom_range(3) == 0) bus.req_a = 1'b1;
            end else if ($urandom_range(19) == 0) bus.req_a = 1'b0;
            if (!bus.req_b) begin
                if ($urandom_range(3) == 0) bus.req_b = 1'b1;
            end else if ($urandom_range(19) == 0) bus.req_b = 1'b0;
            if (!bus.clr_req) begin
                if ($urandom_range(11) == 0) bus.clr_req = 1'b1;
            end else if ($urandom_range(19) == 0) bus.clr_req = 1'b0;
            if ($urandom_range(299) == 0) begin
                rst = 1'b1;
                bus.req_a = 1'b0; bus.req_b = 1'b0; bus.clr_req = 1'b0;
                idle(2);
                rst = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bcd_incr_scheduler.md
# bcd_incr_scheduler

Sequencer and round-robin arbiter that shares one BCD incrementor between two increment requesters and one clear requester. It drives the incrementor's `incr` and `reset` inputs with clean single-cycle strobes. It waits a programmable settle time, captures the 16-bit BCD `data` word and returns it to the served requester with a one-cycle acknowledge. It sits between the event sources (buttons, tick generators) and the BCD incrementor.

## Interface
- `SETTLE_CYCLES`, default 1: cycles waited after a strobe before sampling `cnt_data`; legal range 1..15.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_a`  in  1  increment request, channel A; level, held until `ack_a`.
- `req_b`  in  1  increment request, channel B; level, held until `ack_b`.
- `clr_req`  in  1  clear request; level, held until `clr_ack`.
- `cnt_data`  in  16  BCD word from the incrementor, `{d3,d2,d1,d0}`.
- `cnt_incr`  out  1  increment strobe to the incrementor.
- `cnt_reset`  out  1  clear strobe to the incrementor.
- `ack_a`, `ack_b`, `clr_ack`  out  1 each  one-cycle completion pulses.
- `snap`  out  16  `cnt_data` captured at completion of the last operation.
- `wrap`  out  1  one-cycle pulse: an increment completed with captured value 16'h0000.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Reset.** All outputs are registered. Reset values:
  - `cnt_reset=1`, so the incrementor clears with the system.
  - `cnt_incr`, `ack_*`, `clr_ack`, `wrap` and `busy` are 0.
  - `snap=16'h0000`.
  - State is IDLE and the round-robin pointer is set to A.
  - `cnt_reset` drops on the first clock edge after reset is released.
- **FSM states:** IDLE, STROBE_INC, STROBE_CLR, SETTLE, DONE.
- **IDLE**, evaluated at each edge, in priority order:
  - `clr_req=1`: go to STROBE_CLR.
  - Otherwise, exactly one of `req_a`/`req_b` high: grant it.
  - Otherwise, both high: grant the channel the pointer selects.
  - On a grant, latch the granted channel and go to STROBE_INC.
- **STROBE_INC:** `cnt_incr=1` for exactly one cycle, then SETTLE.
- **STROBE_CLR:** `cnt_reset=1` for exactly one cycle, then SETTLE.
- **SETTLE:** hold for `SETTLE_CYCLES` cycles using a 4-bit down-counter, then DONE. Strobes are 0 throughout.
- **DONE:** one cycle. Actions on entry to DONE:
  - `snap <= cnt_data`.
  - The granted `ack_x` (or `clr_ack`) is high for this cycle only.
  - `wrap=1` if the operation was an increment and `cnt_data==16'h0000`.
  - The pointer moves to the channel not just served; a clear does not move the pointer.
  - Next state is IDLE.
- **Requester rule.** A requester samples its ack on an edge and must drop its request on that same edge. A request still high in the following IDLE cycle is a new request.
- **Wrap rule.** The incrementor counts d2..d0 from 000 to 999 and wraps; d3 stays 0. A wrap is therefore seen as 16'h0000 after an increment. `snap` is passed through unmodified, with no BCD validation.
- **Simultaneous requests.** A clear always wins. Pending increments stay asserted and are served in later transactions, still in round-robin order.
- **Request drop while granted.** If a request drops while its operation is in flight, the operation still completes and the ack is still pulsed.
- **Reset mid-operation.**
  - The transaction is abandoned and no ack is issued.
  - `snap` returns to 0 and `cnt_reset` asserts.
  - The incrementor is thereby cleared.

## Timing
- Request high at IDLE edge E0: STROBE at E0+1, SETTLE from E0+2, DONE (ack) at E0+2+`SETTLE_CYCLES`.
- With the default setting, the ack appears 3 cycles after the request is sampled.
- Per-transaction occupancy is 3+`SETTLE_CYCLES` cycles including the return to IDLE. Back-to-back throughput is one operation per 4 cycles at default.
- `cnt_incr` and `cnt_reset` are never high in the same cycle. Each is never high for more than 1 consecutive cycle, except `cnt_reset` during reset.
- `busy` is high from STROBE through DONE inclusive.

## Test plan
- **Reset release:** `cnt_reset=1` during reset and 0 one edge after release. All other outputs are 0 and `snap=0000`.
- **Single request:** `req_a` with incrementor at 0x0041 and `SETTLE_CYCLES=1`.
  - One `cnt_incr` pulse occurs.
  - `ack_a` arrives 3 cycles after the request is sampled, with `snap=0x0042` and `wrap=0`.
- **Contention:** `req_a` and `req_b` held continuously for 4 transactions.
  - Grant order is A, B, A, B.
  - Each ack pulses exactly once per transaction and the count rises by 4.
- **Clear priority:** `clr_req`, `req_a` and `req_b` asserted together with the count at 0x0123.
  - The clear is served first: `clr_ack` with `snap=0x0000`.
  - Then A and then B are served, with snaps 0x0001 and 0x0002.
- **Wrap:** increment from 0x0999 gives `snap=0x0000`, `wrap=1` for exactly one cycle, and d3 remains 0.
- **Mid-operation reset:** reset asserted during SETTLE.
  - No ack is issued and `cnt_reset=1`.
  - After release, a new `req_b` is served with `snap=0x0001`, and the pointer is back at A.
